// File: rtl/wrapped_instrumented_adder.sv
// ----------------------------------------------------------------------------
// wrapped_instrumented_adder
//
// Purpose:
//   Instrumented 32-bit adder for the user-project harness. Selected bits of
//   operand A can be taken from an external pin (io_in[8]) or from the ring
//   node chain_out. chain_out is an inverted parity of selected sum bits, so
//   feeding it back through the adder makes a ring that toggles while running.
//   Rising edges of chain_out are counted over a programmable window, which
//   measures activity along the adder path.
//
// Ports:
//   wb_clk_i       clock, all state changes on the rising edge
//   wb_rst_n       synchronous active-low reset (wins over active=0)
//   active         project select; 0 freezes state and quiets all outputs
//   la1_data_in    [0] run, [1] clear, [4:2] load select
//   la1_oenb       a control bit in [4:0] is honoured only when its oenb bit is 0
//   la1_data_out   {30'b0, done, chain_out}
//   la2_data_in    load data
//   la2_oenb       unused
//   la2_data_out   current adder sum
//   la3_data_in    window length in clocks (0 = unlimited)
//   la3_oenb       unused
//   la3_data_out   chain_out rising-edge counter
//   io_in          io_in[8] is the external A-bit source
//   io_out         [9] chain_out, [10] run_q, all other bits 0
//   io_oeb         bits 9/10 driven (0) while active, everything else 1
//
// Handshake: there is no valid/ready interface. Loads and control bits are
// level-sensitive and sampled on every clock edge while active=1.
// ----------------------------------------------------------------------------
module wrapped_instrumented_adder (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        active,
  input  logic [31:0] la1_data_in,
  output logic [31:0] la1_data_out,
  input  logic [31:0] la1_oenb,
  input  logic [31:0] la2_data_in,
  output logic [31:0] la2_data_out,
  input  logic [31:0] la2_oenb,
  input  logic [31:0] la3_data_in,
  output logic [31:0] la3_data_out,
  input  logic [31:0] la3_oenb,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  localparam logic [31:0] MASK_RESET = 32'h0000_1000;

  // Load-select encodings
  localparam logic [2:0] SEL_A    = 3'd1;
  localparam logic [2:0] SEL_B    = 3'd2;
  localparam logic [2:0] SEL_EXT  = 3'd3;
  localparam logic [2:0] SEL_RING = 3'd4;
  localparam logic [2:0] SEL_S    = 3'd5;

  // Registered state
  logic [31:0] a_input_q,   a_input_d;
  logic [31:0] b_input_q,   b_input_d;
  logic [31:0] ext_mask_q,  ext_mask_d;   // a_input_ext_bit_b
  logic [31:0] ring_mask_q, ring_mask_d;  // a_input_ring_bit_b
  logic [31:0] s_mask_q,    s_mask_d;     // s_output_bit_b
  logic        chain_q,     chain_d;
  logic        run_q,       run_d;
  logic        done_q,      done_d;
  logic [31:0] timer_q,     timer_d;
  logic [31:0] counter_q,   counter_d;

  // Control decode
  logic        run_cmd;
  logic        clear_cmd;
  logic        load_en;
  logic [2:0]  load_sel;

  assign run_cmd   = la1_data_in[0] & ~la1_oenb[0];
  assign clear_cmd = la1_data_in[1] & ~la1_oenb[1];
  assign load_en   = (la1_oenb[4:2] == 3'b000);
  assign load_sel  = la1_data_in[4:2];

  // Operand mux: external pin beats ring feedback, ring beats the A register.
  logic [31:0] a_eff;
  logic [31:0] sum;

  assign a_eff = (ext_mask_q & {32{io_in[8]}})
               | (~ext_mask_q & ((ring_mask_q & {32{chain_q}})
                                 | (~ring_mask_q & a_input_q)));

  assign sum = a_eff + b_input_q;

  // Window end: last run cycle of an N-clock window is timer == N-1.
  logic window_hit;
  assign window_hit = run_q && (la3_data_in != 32'd0) &&
                      (timer_q == (la3_data_in - 32'd1));

  always_comb begin
    a_input_d   = a_input_q;
    b_input_d   = b_input_q;
    ext_mask_d  = ext_mask_q;
    ring_mask_d = ring_mask_q;
    s_mask_d    = s_mask_q;
    timer_d     = timer_q;
    counter_d   = counter_q;
    done_d      = done_q;

    if (load_en) begin
      case (load_sel)
        SEL_A:    a_input_d   = la2_data_in;
        SEL_B:    b_input_d   = la2_data_in;
        SEL_EXT:  ext_mask_d  = la2_data_in;
        SEL_RING: ring_mask_d = la2_data_in;
        SEL_S:    s_mask_d    = la2_data_in;
        default:  ;
      endcase
    end

    // Ring node: inverted parity of the selected sum bits, held low when idle.
    chain_d = run_q ? ~^(sum & s_mask_q) : 1'b0;

    // done is checked as registered, so run_q falls one cycle after done rises.
    run_d = run_cmd & ~done_q;

    if (run_q) begin
      timer_d = timer_q + 32'd1;
      if (chain_d && !chain_q) begin
        counter_d = counter_q + 32'd1;
      end
    end

    if (window_hit) begin
      done_d = 1'b1;
    end

    // Clear has the last word over counting and window completion.
    if (clear_cmd) begin
      timer_d   = 32'd0;
      counter_d = 32'd0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      a_input_q   <= 32'd0;
      b_input_q   <= 32'd0;
      ext_mask_q  <= MASK_RESET;
      ring_mask_q <= MASK_RESET;
      s_mask_q    <= 32'd0;
      chain_q     <= 1'b0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      timer_q     <= 32'd0;
      counter_q   <= 32'd0;
    end else if (active) begin
      a_input_q   <= a_input_d;
      b_input_q   <= b_input_d;
      ext_mask_q  <= ext_mask_d;
      ring_mask_q <= ring_mask_d;
      s_mask_q    <= s_mask_d;
      chain_q     <= chain_d;
      run_q       <= run_d;
      done_q      <= done_d;
      timer_q     <= timer_d;
      counter_q   <= counter_d;
    end
  end

  // Outputs are gated combinationally so they return the same cycle active does.
  always_comb begin
    la1_data_out = 32'd0;
    la2_data_out = 32'd0;
    la3_data_out = 32'd0;
    io_out       = 38'd0;
    io_oeb       = {38{1'b1}};
    if (active) begin
      la1_data_out = {30'd0, done_q, chain_q};
      la2_data_out = sum;
      la3_data_out = counter_q;
      io_out[9]    = chain_q;
      io_out[10]   = run_q;
      io_oeb[9]    = 1'b0;
      io_oeb[10]   = 1'b0;
    end
  end

  // Inputs that the harness provides but this block does not use.
  logic unused_inputs;
  assign unused_inputs = ^{la1_data_in[31:5], la1_oenb[31:5], la2_oenb,
                           la3_oenb, io_in[37:9], io_in[7:0]};

endmodule

// File: tb/tb_wrapped_instrumented_adder.sv
// ----------------------------------------------------------------------------
// Directed testbench for wrapped_instrumented_adder. Expected values are
// worked out by hand from the block's behaviour and written as constants.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_wrapped_instrumented_adder;

  logic        clk;
  logic        rst_n;
  logic        active;
  logic [31:0] la1_in, la1_out, la1_oenb;
  logic [31:0] la2_in, la2_out, la2_oenb;
  logic [31:0] la3_in, la3_out, la3_oenb;
  logic [37:0] io_in, io_out, io_oeb;

  int n_checks;
  int n_fail;

  localparam logic [37:0] OEB_ACTIVE = 38'h3F_FFFF_F9FF;
  localparam logic [37:0] OEB_IDLE   = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] IO_RUN     = 38'h400;
  localparam logic [37:0] IO_CHAIN   = 38'h200;

  wrapped_instrumented_adder dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .active       (active),
    .la1_data_in  (la1_in),
    .la1_data_out (la1_out),
    .la1_oenb     (la1_oenb),
    .la2_data_in  (la2_in),
    .la2_data_out (la2_out),
    .la2_oenb     (la2_oenb),
    .la3_data_in  (la3_in),
    .la3_data_out (la3_out),
    .la3_oenb     (la3_oenb),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [2:0] sel, input logic [31:0] data);
    la1_in[4:2] = sel;
    la2_in      = data;
    tick(1);
    la1_in[4:2] = 3'd0;
  endtask

  task automatic pulse_clear();
    la1_in[1] = 1'b1;
    tick(1);
    la1_in[1] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    active   = 1'b1;
    la1_in   = '0;
    la1_oenb = '0;
    la2_in   = '0;
    la2_oenb = '1;
    la3_in   = '0;
    la3_oenb = '1;
    io_in    = '0;
    rst_n    = 1'b0;
    tick(1);
    rst_n = 1'b1;

    // Reset state
    check("rst_la3", {6'd0, la3_out}, 38'd0);
    check("rst_la1", {6'd0, la1_out}, 38'd0);
    check("rst_io_out", io_out, 38'd0);
    check("rst_io_oeb", io_oeb, OEB_ACTIVE);
    check("rst_sum", {6'd0, la2_out}, 38'd0);

    // Reset masks put bit 12 on the external pin
    io_in[8] = 1'b1;
    #1;
    check("ext_bit12", {6'd0, la2_out}, 38'h1000);
    load(3'd3, 32'd0);             // ext=0, ring (reset 0x1000) now selects bit 12
    load(3'd1, 32'h0000_1000);     // A bit 12 is masked by ring -> chain_out(0)
    check("ring_over_a", {6'd0, la2_out}, 38'd0);
    load(3'd4, 32'd0);             // ring=0, A register passes through
    check("a_direct", {6'd0, la2_out}, 38'h1000);
    io_in[8] = 1'b0;

    // Adder
    load(3'd1, 32'h0000_0005);
    load(3'd2, 32'h0000_0007);
    check("add_5_7", {6'd0, la2_out}, 38'h0000_000C);
    load(3'd6, 32'hDEAD_BEEF);     // select 6 writes nothing
    check("sel6_noop", {6'd0, la2_out}, 38'h0000_000C);
    load(3'd1, 32'hFFFF_FFFF);
    load(3'd2, 32'hFFFF_FFFF);
    check("add_carry_drop", {6'd0, la2_out}, 38'hFFFF_FFFE);

    // Oscillation: ring=s=bit12, a=b=0, unlimited window
    load(3'd1, 32'd0);
    load(3'd2, 32'd0);
    load(3'd4, 32'h0000_1000);
    load(3'd5, 32'h0000_1000);
    la3_in    = 32'd0;
    la1_in[0] = 1'b1;
    tick(1);                       // run_q rises, chain still 0
    check("osc_run_q", io_out, IO_RUN);
    check("osc_chain0", {6'd0, la1_out}, 38'd0);
    tick(1);
    check("osc_chain1", {6'd0, la1_out}, 38'd1);
    tick(1);
    check("osc_chain2", {6'd0, la1_out}, 38'd0);
    tick(7);                       // 10 clocks with run=1
    la1_in[0] = 1'b0;
    tick(2);                       // run_q drains one edge later
    check("osc_count", {6'd0, la3_out}, 38'd5);
    check("osc_idle_io", io_out, 38'd0);

    // Window of 8: done on the 8th run cycle, one trailing run cycle follows
    pulse_clear();
    check("clr_count", {6'd0, la3_out}, 38'd0);
    la3_in    = 32'd8;
    la1_in[0] = 1'b1;
    tick(9);
    check("win_done", {6'd0, la1_out}, 38'h2);
    check("win_count8", {6'd0, la3_out}, 38'd4);
    check("win_run_tail", io_out, IO_RUN);
    tick(1);
    check("win_count9", {6'd0, la3_out}, 38'd5);
    check("win_run_fell", io_out, IO_CHAIN);
    tick(3);
    check("win_frozen", {6'd0, la3_out}, 38'd5);
    check("win_done_hold", {6'd0, la1_out}, 38'h2);
    la1_in[0] = 1'b0;
    pulse_clear();
    check("win_clr_count", {6'd0, la3_out}, 38'd0);
    check("win_clr_done", {6'd0, la1_out}, 38'd0);
    la3_in = 32'd0;

    // Gating
    la1_in[0] = 1'b1;
    tick(5);
    check("gate_pre", {6'd0, la3_out}, 38'd2);
    active = 1'b0;
    #1;
    check("gate_la1", {6'd0, la1_out}, 38'd0);
    check("gate_la2", {6'd0, la2_out}, 38'd0);
    check("gate_la3", {6'd0, la3_out}, 38'd0);
    check("gate_io_out", io_out, 38'd0);
    check("gate_io_oeb", io_oeb, OEB_IDLE);
    tick(3);
    active = 1'b1;
    #1;
    check("gate_resume_cnt", {6'd0, la3_out}, 38'd2);
    check("gate_resume_io", io_out, IO_RUN);
    tick(1);
    check("gate_count_on", {6'd0, la3_out}, 38'd3);

    // oenb masks the run bit
    la1_in[0] = 1'b0;
    pulse_clear();
    tick(1);
    check("oenb_pre", {6'd0, la3_out}, 38'd0);
    la1_oenb[0] = 1'b1;
    la1_in[0]   = 1'b1;
    tick(4);
    check("oenb_run_q", io_out, 38'd0);
    check("oenb_count", {6'd0, la3_out}, 38'd0);
    la1_oenb[0] = 1'b0;

    // Reset mid-measurement
    tick(4);
    check("mid_count", {6'd0, la3_out}, 38'd2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    la1_in[0] = 1'b0;
    check("mid_rst_count", {6'd0, la3_out}, 38'd0);
    check("mid_rst_io", io_out, 38'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
